// File: rtl/instruction_loader.sv
// Instruction loader: encodes incoming instruction field bundles into 32-bit
// words, buffers them in a 4-entry FIFO and writes them through a single
// output register to consecutive instruction-memory addresses.
module instruction_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  base_addr,
  input  logic [8:0]  word_count,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  condition_in,
  input  logic [3:0]  op_code_in,
  input  logic [3:0]  destination_in,
  input  logic [3:0]  src1_in,
  input  logic [3:0]  src2_in,
  input  logic        s_bit_in,
  input  logic        imm_sel_in,
  input  logic [15:0] immediat_value_in,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic        busy_r;
  logic        done_r;
  logic [8:0]  word_count_r;
  logic [8:0]  acc_cnt_r;
  logic [8:0]  wr_cnt_r;
  logic [7:0]  next_addr_r;

  logic [31:0] fifo_mem_r [4];
  logic [1:0]  wr_ptr_r;
  logic [1:0]  rd_ptr_r;
  logic [2:0]  fifo_cnt_r;

  logic        out_valid_r;
  logic [7:0]  out_addr_r;
  logic [31:0] out_data_r;

  logic        in_ready_s;
  logic        push_s;
  logic        pop_s;
  logic        complete_s;
  logic        last_write_s;
  logic [31:0] enc_word_s;

  // Instruction word layout; unused source or immediate fields are dropped.
  function automatic logic [31:0] encode_word(
    input logic [3:0]  cond,
    input logic [3:0]  op,
    input logic        s_bit,
    input logic [3:0]  dst,
    input logic [3:0]  src1,
    input logic [3:0]  src2,
    input logic        imm_sel,
    input logic [15:0] imm
  );
    logic [15:0] operand;
    if (imm_sel) begin
      operand = imm;
    end else begin
      operand = {src2, src1, 8'd0};
    end
    return {cond, op, s_bit, dst, operand, 3'd0};
  endfunction

  // Handshake decode: accept while loading, FIFO has room and words remain.
  always_comb begin
    in_ready_s   = (state_r == ST_LOAD) && (fifo_cnt_r != 3'd4) &&
                   (acc_cnt_r < word_count_r);
    push_s       = in_valid && in_ready_s;
    complete_s   = out_valid_r && mem_ready;
    pop_s        = (fifo_cnt_r != 3'd0) && (!out_valid_r || complete_s);
    last_write_s = complete_s && ((wr_cnt_r + 9'd1) == word_count_r);
    enc_word_s   = encode_word(condition_in, op_code_in, s_bit_in, destination_in,
                               src1_in, src2_in, imm_sel_in, immediat_value_in);
  end

  // Control FSM with transfer counters and registered busy/done flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      word_count_r <= 9'd0;
      acc_cnt_r    <= 9'd0;
      wr_cnt_r     <= 9'd0;
      next_addr_r  <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            word_count_r <= word_count;
            acc_cnt_r    <= 9'd0;
            wr_cnt_r     <= 9'd0;
            next_addr_r  <= base_addr;
            if (word_count == 9'd0) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_LOAD;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (push_s) begin
            acc_cnt_r <= acc_cnt_r + 9'd1;
          end
          if (pop_s) begin
            next_addr_r <= next_addr_r + 8'd1;
          end
          if (complete_s) begin
            wr_cnt_r <= wr_cnt_r + 9'd1;
          end
          if (last_write_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_LOAD;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Encoded-word FIFO; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem_r[i] <= 32'd0;
      end
      wr_ptr_r   <= 2'd0;
      rd_ptr_r   <= 2'd0;
      fifo_cnt_r <= 3'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= enc_word_s;
        wr_ptr_r             <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + 3'd1;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - 3'd1;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Output register: refills from the FIFO head when empty or completing, else holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_addr_r  <= 8'd0;
      out_data_r  <= 32'd0;
    end else begin
      if (pop_s) begin
        out_valid_r <= 1'b1;
        out_addr_r  <= next_addr_r;
        out_data_r  <= fifo_mem_r[rd_ptr_r];
      end else if (complete_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign mem_we    = out_valid_r;
  assign mem_addr  = out_addr_r;
  assign mem_wdata = out_data_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader.
module tb_instruction_loader;

  typedef struct packed {
    logic [3:0]  cond;
    logic [3:0]  op;
    logic        s;
    logic [3:0]  dst;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        imm_sel;
    logic [15:0] imm;
  } bundle_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  word_count;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  condition_in;
  logic [3:0]  op_code_in;
  logic [3:0]  destination_in;
  logic [3:0]  src1_in;
  logic [3:0]  src2_in;
  logic        s_bit_in;
  logic        imm_sel_in;
  logic [15:0] immediat_value_in;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        busy;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          acc_seen = 0;
  bit          abort_stream = 1'b0;
  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          wt_q[$];
  bundle_t     vec[16];

  instruction_loader dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .base_addr         (base_addr),
    .word_count        (word_count),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .condition_in      (condition_in),
    .op_code_in        (op_code_in),
    .destination_in    (destination_in),
    .src1_in           (src1_in),
    .src2_in           (src2_in),
    .s_bit_in          (s_bit_in),
    .imm_sel_in        (imm_sel_in),
    .immediat_value_in (immediat_value_in),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_ready         (mem_ready),
    .busy              (busy),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-side monitor: records completed writes, accepts and done pulses.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset && mem_we && mem_ready) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      wt_q.push_back(cyc);
    end
    if (reset && in_valid && in_ready) acc_seen <= acc_seen + 1;
    if (reset && done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tb_encode(input bundle_t b);
    logic [31:0] w;
    w = (32'(b.cond) << 28) | (32'(b.op) << 24) | (32'(b.s) << 23) | (32'(b.dst) << 19);
    if (b.imm_sel) w = w | (32'(b.imm) << 3);
    else           w = w | (32'(b.src2) << 15) | (32'(b.src1) << 11);
    return w;
  endfunction

  task automatic fill(input int seed, input bit force_reg);
    for (int k = 0; k < 16; k++) begin
      vec[k].cond    = 4'(seed + k);
      vec[k].op      = 4'(seed * 3 + k);
      vec[k].s       = 1'(k);
      vec[k].dst     = 4'(k + 5);
      vec[k].src1    = 4'(seed + 2 * k);
      vec[k].src2    = 4'(15 - k);
      vec[k].imm_sel = force_reg ? 1'b0 : 1'(k + 1);
      vec[k].imm     = 16'(seed * 4097 + k * 257);
    end
  endtask

  task automatic drive(input bundle_t b);
    condition_in      = b.cond;
    op_code_in        = b.op;
    s_bit_in          = b.s;
    destination_in    = b.dst;
    src1_in           = b.src1;
    src2_in           = b.src2;
    imm_sel_in        = b.imm_sel;
    immediat_value_in = b.imm;
  endtask

  // Called at a negedge; holds in_valid high and advances on every accept.
  task automatic stream(input int n);
    int sent = 0;
    int guard = 0;
    drive(vec[0]);
    in_valid = 1'b1;
    while (sent < n && guard < 400 && !abort_stream) begin
      if (in_ready) begin
        @(negedge clk);
        sent++;
        if (sent < n) drive(vec[sent]);
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    in_valid = 1'b0;
    if (!abort_stream && sent < n) chk("stream_timeout", 32'(sent), 32'(n));
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] c);
    start      = 1'b1;
    base_addr  = b;
    word_count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_writes(input int s0, input int n, input logic [7:0] base);
    logic [7:0] a;
    chk("write_count", 32'(wa_q.size() - s0), 32'(n));
    for (int i = 0; i < n && (s0 + i) < wa_q.size(); i++) begin
      a = base + 8'(i);
      chk("write_addr", 32'(wa_q[s0 + i]), 32'(a));
      chk("write_data", wd_q[s0 + i], tb_encode(vec[i]));
    end
  endtask

  initial begin
    int s0;
    int d0;
    int g;
    logic [7:0]  hold_addr;
    logic [31:0] hold_data;

    reset = 1'b0; start = 1'b0; base_addr = 8'd0; word_count = 9'd0;
    in_valid = 1'b0; mem_ready = 1'b0;
    fill(0, 1'b0);
    drive(vec[0]);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Immediate-form encoding and minimum latency, memory stalled at first
    vec[0] = '{cond: 4'hE, op: 4'h3, s: 1'b1, dst: 4'h5, src1: 4'hF, src2: 4'hF,
               imm_sel: 1'b1, imm: 16'hABCD};
    mem_ready = 1'b0;
    do_start(8'h40, 9'd1);
    stream(1);
    chk("latency_n", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("latency_n1", 32'(mem_we), 32'd1);
    chk("imm_addr", 32'(mem_addr), 32'h40);
    chk("imm_word", mem_wdata, 32'hE3AD5E68);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("imm_done", 32'(done), 32'd1);
    chk("imm_we_clear", 32'(mem_we), 32'd0);
    @(negedge clk);

    // Register-form encoding
    vec[0] = '{cond: 4'h0, op: 4'h1, s: 1'b0, dst: 4'h2, src1: 4'h7, src2: 4'h9,
               imm_sel: 1'b0, imm: 16'hFFFF};
    s0 = wa_q.size();
    do_start(8'h50, 9'd1);
    stream(1);
    wait_done();
    @(negedge clk);
    chk("reg_count", 32'(wa_q.size() - s0), 32'd1);
    if (wa_q.size() > s0) chk("reg_word", wd_q[s0], 32'h0114B800);

    // Three register-form words at 0x10; restart during load is ignored
    fill(3, 1'b1);
    s0 = wa_q.size();
    d0 = done_cnt;
    do_start(8'h10, 9'd3);
    do_start(8'h99, 9'd1);
    chk("busy_load", 32'(busy), 32'd1);
    stream(3);
    wait_done();
    chk("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    check_writes(s0, 3, 8'h10);

    // Address wrap and one-word-per-cycle throughput
    fill(5, 1'b0);
    s0 = wa_q.size();
    do_start(8'hFE, 9'd4);
    stream(4);
    wait_done();
    @(negedge clk);
    check_writes(s0, 4, 8'hFE);
    if (wt_q.size() >= s0 + 4) chk("throughput", 32'(wt_q[s0 + 3] - wt_q[s0]), 32'd3);

    // Backpressure: 5 words absorbed while memory stalls, then drained in order
    fill(9, 1'b0);
    s0 = wa_q.size();
    mem_ready = 1'b0;
    do_start(8'h30, 9'd8);
    acc_seen = 0;
    fork
      stream(8);
    join_none
    repeat (3) @(negedge clk);
    hold_addr = mem_addr;
    hold_data = mem_wdata;
    repeat (9) @(negedge clk);
    chk("stall_accepted", 32'(acc_seen), 32'd5);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_we", 32'(mem_we), 32'd1);
    chk("stall_addr_hold", 32'(mem_addr), 32'(hold_addr));
    chk("stall_addr", 32'(mem_addr), 32'h30);
    chk("stall_data_hold", mem_wdata, hold_data);
    chk("stall_data", mem_wdata, tb_encode(vec[0]));
    mem_ready = 1'b1;
    wait_done();
    @(negedge clk);
    check_writes(s0, 8, 8'h30);

    // Zero-length load: done one cycle after start, no writes
    s0 = wa_q.size();
    do_start(8'h77, 9'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("zero_done_drop", 32'(done), 32'd0);
    chk("zero_writes", 32'(wa_q.size() - s0), 32'd0);

    // Reset mid-load after two writes
    fill(12, 1'b0);
    s0 = wa_q.size();
    abort_stream = 1'b0;
    do_start(8'h20, 9'd6);
    fork
      stream(6);
    join_none
    g = 0;
    while (wa_q.size() < s0 + 2 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("abort_two_writes", 32'(wa_q.size() - s0), 32'd2);
    reset = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    chk("abort_wdata", mem_wdata, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    abort_stream = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_writes", 32'(wa_q.size() - s0), 32'd2);
    chk("abort_we_idle", 32'(mem_we), 32'd0);
    chk("abort_busy_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low, ports named as below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle load request; honoured only in IDLE.
REQ-005 base_addr  input  8  first instruction-memory address of the program, latched on start.
REQ-006 word_count  input  9  number of words to load (0..256), latched on start.
REQ-007 in_valid  input  1  field bundle valid.
REQ-008 in_ready  output  1  block accepts a bundle this cycle.
REQ-009 condition_in, op_code_in, destination_in, src1_in, src2_in  input  4 each  instruction fields.
REQ-010 s_bit_in  input  1  set-flags bit.
REQ-011 imm_sel_in  input  1  1 = immediate form, 0 = register form.
REQ-012 immediat_value_in  input  16  immediate field.
REQ-013 mem_we  output  1  write request to instruction memory.
REQ-014 mem_addr  output  8  write address.
REQ-015 mem_wdata  output  32  encoded instruction word.
REQ-016 mem_ready  input  1  memory accepts a write when high with mem_we high.
REQ-017 busy  output  1  high in LOAD.
REQ-018 done  output  1  one-cycle pulse when a load completes.

Function
REQ-019 Encoding SHALL be: [31:28] condition, [27:24] op_code, [23] s_bit, [22:19] destination, [2:0] 0.
REQ-020 imm_sel=1: [18:3] = immediat_value; src1/src2 ignored.
REQ-021 imm_sel=0: [18:15] = src2, [14:11] = src1, [10:3] = 0; immediate ignored.
REQ-022 States SHALL be IDLE, LOAD, DONE; IDLE->LOAD on start with word_count!=0; IDLE->DONE on start with word_count==0; LOAD->DONE on the cycle the last write completes; DONE->IDLE unconditionally after one cycle.
REQ-023 done SHALL be high exactly while in DONE; busy exactly while in LOAD.
REQ-024 start outside IDLE SHALL be ignored (no relatch, no restart).
REQ-025 Encoded words SHALL be buffered in a 4-entry FIFO followed by one output register driving mem_we/mem_addr/mem_wdata.
REQ-026 in_ready = (state==LOAD) and FIFO not full and accepted-count < word_count; transfer occurs when in_valid and in_ready are both high at a clock edge.
REQ-027 A write completes on an edge with mem_we and mem_ready both high; mem_we/mem_addr/mem_wdata SHALL hold stable until completion.
REQ-028 Output register SHALL load FIFO head on any edge where it is empty or completing; simultaneous FIFO push and pop SHALL keep occupancy unchanged.
REQ-029 Minimum latency: bundle accepted at edge N with FIFO and output register empty -> mem_we high after edge N+1.
REQ-030 Sustained throughput with in_valid and mem_ready held high SHALL be one word per cycle.
REQ-031 mem_addr SHALL start at base_addr and increment by 1 per completed write, wrapping 255->0.
REQ-032 Word order in memory SHALL equal acceptance order; no word dropped or duplicated.
REQ-033 in_valid in IDLE/DONE SHALL be ignored (in_ready low).

Reset
REQ-034 While reset is low: state IDLE, FIFO empty, counters 0, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0.
REQ-035 Reset asserted mid-LOAD SHALL abort immediately; buffered words discarded; no write issued after release until a new start.

Verification
REQ-036 start, base=0x10, count=3, three register-form bundles, mem_ready=1 -> writes at 0x10,0x11,0x12, done pulses once, busy falls same cycle.
REQ-037 cond=0xE, op=0x3, s=1, dst=0x5, imm_sel=1, imm=0xABCD -> mem_wdata=0xE3AD5E68.
REQ-038 cond=0x0, op=0x1, s=0, dst=0x2, src1=0x7, src2=0x9, imm_sel=0 -> mem_wdata=0x0114B800.
REQ-039 base=0xFE, count=4 -> addresses 0xFE,0xFF,0x00,0x01.
REQ-040 mem_ready low 10 cycles, count=8, in_valid high -> exactly 5 accepted (4 FIFO + 1 output), in_ready low, mem_we/addr/data stable; release -> all 8 written in order.
REQ-041 count=0 -> done pulse one cycle after start, no mem_we; reset low mid-load of 6 words after 2 writes -> all outputs zero, no further writes.
